// File: rtl/alu_exec_if.sv
// Handshake and result bus between the ID/EX stage, the execute ALU and EX/MEM.
// The master drives operations in; the slave (the ALU) returns results and HI/LO.
interface alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, alu_op, funct, src_a, src_b,
        input  in_ready, out_valid, result, zero, illegal, hi, lo
    );

    modport slave (
        input  in_valid, alu_op, funct, src_a, src_b,
        output in_ready, out_valid, result, zero, illegal, hi, lo
    );
endinterface

// File: rtl/alu_exec_unit.sv
// MIPS execute-stage ALU: single-cycle ops with a registered result, plus
// iterative shift-add multiply and restoring divide into HI/LO.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_exec_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    localparam int W2 = 2 * WIDTH;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   res_p1;
    logic               vld_p1;
    logic               zero_p1;
    logic               ill_p1;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic [W2-1:0]      acc_p0;
    logic [WIDTH-1:0]   opb_p0;
    logic [WIDTH-1:0]   a_raw_p0;
    logic               is_div_p0;
    logic               neg_q_p0;
    logic               neg_r_p0;
    logic               dz_p0;

    logic               accept;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_ill;
    logic               it_start;
    logic               it_div;
    logic               it_signed;

    logic [WIDTH:0]     mul_sum;
    logic [W2-1:0]      mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [W2-1:0]      div_next;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [W2-1:0] apply_sign2(input logic [W2-1:0] v, input logic neg);
        return neg ? (~v + W2'(1)) : v;
    endfunction

    assign accept   = bus.in_valid & bus.in_ready;
    assign a_s      = bus.src_a;
    assign b_s      = bus.src_b;

    always_comb begin
        sc_res    = '0;
        sc_ill    = 1'b0;
        it_start  = 1'b0;
        it_div    = 1'b0;
        it_signed = 1'b0;
        case (bus.alu_op)
            2'b00: sc_res = bus.src_a + bus.src_b;
            2'b01: sc_res = bus.src_a - bus.src_b;
            2'b11: sc_res = bus.src_a & bus.src_b;
            default: begin
                case (bus.funct)
                    F_ADD:   sc_res = bus.src_a + bus.src_b;
                    F_SUB:   sc_res = bus.src_a - bus.src_b;
                    F_AND:   sc_res = bus.src_a & bus.src_b;
                    F_OR:    sc_res = bus.src_a | bus.src_b;
                    F_NOR:   sc_res = ~(bus.src_a | bus.src_b);
                    F_SLT:   sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
                    F_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
                    F_MFHI:  sc_res = hi_q;
                    F_MFLO:  sc_res = lo_q;
                    F_MULT:  begin it_start = 1'b1; it_signed = 1'b1; end
                    F_MULTU: it_start = 1'b1;
                    F_DIV:   begin it_start = 1'b1; it_div = 1'b1; it_signed = 1'b1; end
                    F_DIVU:  begin it_start = 1'b1; it_div = 1'b1; end
                    default: sc_ill = 1'b1;
                endcase
            end
        endcase
    end

    // Iteration step: upper half accumulates (mul) or holds the partial remainder (div)
    always_comb begin
        mul_sum  = {1'b0, acc_p0[W2-1:WIDTH]} + {1'b0, (acc_p0[0] ? opb_p0 : {WIDTH{1'b0}})};
        mul_next = {mul_sum, acc_p0[WIDTH-1:1]};
        rem_sh   = {acc_p0[W2-1:WIDTH], acc_p0[WIDTH-1]};
        diff     = rem_sh - {1'b0, opb_p0};
        if (!diff[WIDTH]) begin
            div_next = {diff[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {rem_sh[WIDTH-1:0], acc_p0[WIDTH-2:0], 1'b0};
        end
    end

    // Divide-by-zero bypasses sign correction so HI keeps the raw dividend
    always_comb begin
        fix_hi = '0;
        fix_lo = '0;
        if (is_div_p0) begin
            if (dz_p0) begin
                fix_lo = '1;
                fix_hi = a_raw_p0;
            end else begin
                fix_lo = apply_sign(acc_p0[WIDTH-1:0], neg_q_p0);
                fix_hi = apply_sign(acc_p0[W2-1:WIDTH], neg_r_p0);
            end
        end else begin
            {fix_hi, fix_lo} = apply_sign2(acc_p0, neg_q_p0);
        end
    end

    // Stage p0: operand latch and iteration datapath
    always_ff @(posedge clk) begin
        if (accept && it_start) begin
            opb_p0    <= magnitude(bus.src_b, it_signed);
            acc_p0    <= {{WIDTH{1'b0}}, magnitude(bus.src_a, it_signed)};
            a_raw_p0  <= bus.src_a;
            is_div_p0 <= it_div;
            neg_q_p0  <= it_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
            neg_r_p0  <= it_signed & bus.src_a[WIDTH-1];
            dz_p0     <= (bus.src_b == '0);
        end else if (state == MUL) begin
            acc_p0 <= mul_next;
        end else if (state == DIV) begin
            acc_p0 <= div_next;
        end
    end

    // Stage p1: control FSM, registered result and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            res_p1  <= '0;
            vld_p1  <= 1'b0;
            zero_p1 <= 1'b0;
            ill_p1  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            vld_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (it_start) begin
                            state <= it_div ? DIV : MUL;
                            cnt   <= CNT_W'(WIDTH);
                        end else begin
                            res_p1  <= sc_res;
                            zero_p1 <= (sc_res == '0);
                            ill_p1  <= sc_ill;
                            vld_p1  <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi_q    <= fix_hi;
                    lo_q    <= fix_lo;
                    res_p1  <= fix_lo;
                    zero_p1 <= (fix_lo == '0);
                    ill_p1  <= 1'b0;
                    vld_p1  <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = vld_p1;
    assign bus.result    = res_p1;
    assign bus.zero      = zero_p1;
    assign bus.illegal   = ill_p1;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed MIPS cases plus randomized ops, checked
// cycle by cycle against an arithmetic reference model with HI/LO state.
module tb_alu_exec_unit;
    localparam int W   = 32;
    localparam int ITL = W + 1;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic        zero;
        logic        ill;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic clk;
    logic rst_n;

    alu_exec_if #(.WIDTH(W)) bus ();

    alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    int          busy_last = -1;
    int          acc_cyc = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;
    exp_t        exp_q[$];
    logic [31:0] res_hist[$];
    logic        zero_hist[$];
    logic        ill_hist[$];
    int          cyc_hist[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Reference model: whole-operation arithmetic, HI/LO as architectural state
    task automatic model_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, output logic [31:0] r, output logic ill,
                            output logic iter);
        longint      sa, sb, q, rm;
        logic [63:0] p;
        r = '0; ill = 1'b0; iter = 1'b0;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        case (op)
            2'd0: r = a + b;
            2'd1: r = a - b;
            2'd3: r = a & b;
            default: begin
                case (f)
                    6'h20: r = a + b;
                    6'h22: r = a - b;
                    6'h24: r = a & b;
                    6'h25: r = a | b;
                    6'h27: r = ~(a | b);
                    6'h2A: r = (sa < sb) ? 32'd1 : 32'd0;
                    6'h2B: r = (a < b) ? 32'd1 : 32'd0;
                    6'h10: r = mhi;
                    6'h12: r = mlo;
                    6'h18: begin p = 64'(sa * sb); {mhi, mlo} = p; iter = 1'b1; end
                    6'h19: begin p = {32'h0, a} * {32'h0, b}; {mhi, mlo} = p; iter = 1'b1; end
                    6'h1A, 6'h1B: begin
                        iter = 1'b1;
                        if (b == 0) begin
                            mlo = '1; mhi = a;
                        end else if (f == 6'h1A) begin
                            q = sa / sb; rm = sa % sb;
                            mlo = q[31:0]; mhi = rm[31:0];
                        end else begin
                            mlo = a / b; mhi = a % b;
                        end
                    end
                    default: begin r = '0; ill = 1'b1; end
                endcase
            end
        endcase
        if (iter) r = mlo;
    endtask

    task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b);
        int   guard;
        exp_t e;
        logic iter;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.alu_op = op; bus.funct = f; bus.src_a = a; bus.src_b = b;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        model_op(op, f, a, b, e.res, e.ill, iter);
        acc_cyc = cyc + 1;
        e.due   = iter ? acc_cyc + ITL : acc_cyc;
        e.zero  = (e.res == 0);
        e.hi    = mhi;
        e.lo    = mlo;
        if (iter) busy_last = acc_cyc + ITL - 1;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle_wait();
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while ((exp_q.size() != 0 || !bus.in_ready) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    // Compare process: every cycle, #1 after the rising edge
    initial begin
        exp_t e;
        logic exp_ov;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            exp_ov = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("in_ready", 32'(bus.in_ready), 32'(cyc > busy_last));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            if (exp_ov) begin
                e = exp_q.pop_front();
                if (bus.out_valid) begin
                    chk("result", bus.result, e.res);
                    chk("zero", 32'(bus.zero), 32'(e.zero));
                    chk("illegal", 32'(bus.illegal), 32'(e.ill));
                    chk("hi", bus.hi, e.hi);
                    chk("lo", bus.lo, e.lo);
                end
            end
            if (bus.out_valid) begin
                res_hist.push_back(bus.result);
                zero_hist.push_back(bus.zero);
                ill_hist.push_back(bus.illegal);
                cyc_hist.push_back(cyc);
            end
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        logic [5:0] f;
        logic [5:0] flist [13];
        flist = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h2B,
                  6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.alu_op = '0; bus.funct = '0; bus.src_a = '0; bus.src_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst_n = 1'b1;

        issue(2'b00, 6'h00, 32'd5, 32'd7);
        issue(2'b01, 6'h00, 32'd3, 32'd3);
        idle_wait();
        chk("add_res", res_hist[$-1], 32'd12);
        chk("add_zero", 32'(zero_hist[$-1]), 32'd0);
        chk("sub_res", res_hist[$], 32'd0);
        chk("sub_zero", 32'(zero_hist[$]), 32'd1);
        chk("b2b_gap", 32'(cyc_hist[$] - cyc_hist[$-1]), 32'd1);

        issue(2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1);
        idle_wait();
        chk("slt_res", res_hist[$], 32'd1);
        issue(2'b10, 6'h2B, 32'hFFFF_FFFF, 32'd1);
        idle_wait();
        chk("sltu_res", res_hist[$], 32'd0);
        issue(2'b10, 6'h3F, 32'h1234, 32'h5678);
        idle_wait();
        chk("ill_flag", 32'(ill_hist[$]), 32'd1);
        chk("ill_res", res_hist[$], 32'd0);

        issue(2'b10, 6'h18, -32'd3, 32'd5);
        idle_wait();
        chk("mult_lat", 32'(cyc_hist[$] - acc_cyc), 32'd33);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFF1);
        issue(2'b10, 6'h10, 32'd0, 32'd0);
        idle_wait();
        chk("mfhi_res", res_hist[$], 32'hFFFF_FFFF);

        issue(2'b10, 6'h1A, -32'd7, 32'd2);
        idle_wait();
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        issue(2'b10, 6'h1B, 32'd7, 32'd0);
        idle_wait();
        chk("divu0_lo", bus.lo, 32'hFFFF_FFFF);
        chk("divu0_hi", bus.hi, 32'd7);
        issue(2'b10, 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_wait();
        chk("divmin_lo", bus.lo, 32'h8000_0000);
        chk("divmin_hi", bus.hi, 32'd0);
        issue(2'b10, 6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle_wait();
        chk("multu_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_lo", bus.lo, 32'h0000_0001);

        // Abort a divide partway through with a one-cycle reset pulse
        issue(2'b10, 6'h1B, 32'd1000, 32'd3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        busy_last = -1;
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_hi", bus.hi, 32'd0);
        chk("abort_lo", bus.lo, 32'd0);
        chk("abort_ready", 32'(bus.in_ready), 32'd1);
        repeat (40) @(negedge clk);
        issue(2'b00, 6'h00, 32'd2, 32'd2);
        idle_wait();
        chk("post_abort_add", res_hist[$], 32'd4);

        for (int i = 0; i < 400; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = flist[$urandom_range(0, 12)];
            if ($urandom_range(0, 11) == 0) f = 6'($urandom);
            issue(op, f, pick_operand(), pick_operand());
            if ($urandom_range(0, 5) == 0) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        idle_wait();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
